// File: rtl/wb_prefetch_pkg.sv
// rtl/wb_prefetch_pkg.sv - shared bus constants and FSM encoding for the instruction prefetcher
package wb_prefetch_pkg;
  localparam logic [3:0]  WB_SEL_WORD = 4'hF;
  localparam logic [31:0] WORD_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/wb_sync_fifo.sv
// rtl/wb_sync_fifo.sv - synchronous FIFO with flush, count and full/empty flags
module wb_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A pop frees a slot in the same cycle, so push is accepted even when full.
  assign w_pop  = pop_i && (r_count != '0);
  assign w_push = push_i && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
endmodule

// File: rtl/wb_prefetch.sv
// rtl/wb_prefetch.sv - pipelined Wishbone read master prefetching sequential instruction words
module wb_prefetch #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);
  import wb_prefetch_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t         r_state;
  logic [31:0]    r_adr;
  logic           r_stb;
  logic           r_cyc;
  logic [CW-1:0]  r_outstanding;

  logic           w_issue;
  logic           w_ack;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_fifo_count;
  logic [CW-1:0]  w_out_next;
  logic [CW-1:0]  w_cnt_next;
  logic           w_credit;
  logic [31:0]    w_target;
  logic [31:0]    w_ack_pc;
  logic [63:0]    w_head;

  assign w_issue  = r_stb && !wb_stall_i;
  assign w_ack    = wb_ack_i && (r_outstanding != '0);
  assign w_target = redirect_pc_i & ~32'h3;
  // In FETCH every pending read belongs to the current sequential stream.
  assign w_ack_pc = r_adr - (32'(r_outstanding) << 2);

  assign w_pop  = !w_empty && instr_ready_i && !redirect_i;
  assign w_push = w_ack && (r_state == ST_FETCH) && !redirect_i && (!w_full || w_pop);

  assign w_out_next = r_outstanding + CW'(w_issue) - CW'(w_ack);
  assign w_cnt_next = redirect_i ? '0 : w_fifo_count + CW'(w_push) - CW'(w_pop);
  assign w_credit   = ({1'b0, w_out_next} + {1'b0, w_cnt_next}) < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_adr         <= RESET_PC;
      r_stb         <= 1'b0;
      r_cyc         <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_out_next;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
          r_stb   <= 1'b1;
          r_cyc   <= 1'b1;
          if (redirect_i) r_adr <= w_target;
        end
        ST_FETCH: begin
          if (redirect_i) begin
            r_adr <= w_target;
            r_cyc <= 1'b1;
            if (w_out_next == '0) begin
              r_stb <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
              r_stb   <= 1'b0;
            end
          end else begin
            if (w_issue) r_adr <= r_adr + WORD_STEP;
            r_stb <= w_credit;
            r_cyc <= w_credit || (w_out_next != '0);
          end
        end
        ST_DRAIN: begin
          if (redirect_i) r_adr <= w_target;
          r_cyc <= 1'b1;
          if (w_out_next == '0) begin
            r_state <= ST_FETCH;
            r_stb   <= 1'b1;
          end else begin
            r_stb <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_stb   <= 1'b0;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

  wb_sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (w_push),
    .data_i  ({w_ack_pc, wb_dat_i}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_fifo_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign wb_adr_o      = r_adr;
  assign wb_we_o       = 1'b0;
  assign wb_sel_o      = WB_SEL_WORD;
  assign wb_cyc_o      = r_cyc;
  assign wb_stb_o      = r_stb;
  assign instr_valid_o = !w_empty;
  assign instr_pc_o    = w_head[63:32];
  assign instr_o       = w_head[31:0];
endmodule
